pipeline_ctrl: RTL



---
 rtl/pipeline_ctrl_pkg.sv | 12 +
 rtl/pipeline_ctrl_load_use_detect.sv | 20 ++
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and default counter width for pipeline_ctrl
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MEMWAIT = 2'b10
  } state_e;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - load-use hazard comparator between EX load and ID sources
module load_use_detect (
  input  logic       mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  output logic       hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_use_i && (ex_rd_i == id_rs1_i);
  assign rs2_hit  = id_rs2_use_i && (ex_rd_i == id_rs2_i);
  // x0 is never a real destination, so a load targeting it cannot create a dependency
  assign hazard_o = mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer with memory freeze and saturating perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_Rd_i,
  input  logic [4:0]       IF_ID_RS1_i,
  input  logic [4:0]       IF_ID_RS2_i,
  input  logic             IF_ID_RS1_use_i,
  input  logic             IF_ID_RS2_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             pipe_hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic freeze;
  logic active;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;

  load_use_detect u_load_use_detect (
    .mem_read_i   (ID_EX_MemRead_i),
    .ex_rd_i      (ID_EX_Rd_i),
    .id_rs1_i     (IF_ID_RS1_i),
    .id_rs2_i     (IF_ID_RS2_i),
    .id_rs1_use_i (IF_ID_RS1_use_i),
    .id_rs2_use_i (IF_ID_RS2_use_i),
    .hazard_o     (hazard)
  );

  // Once in MEM_WAIT the access is outstanding regardless of mem_req_i; only the ack releases it
  assign freeze = !mem_ack_i && ((state_q == ST_MEMWAIT) || mem_req_i);
  assign active = (state_q == ST_RUN) || (state_q == ST_MEMWAIT);

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b1;
    case (state_q)
      ST_RUN, ST_MEMWAIT: begin
        if (freeze) begin
          state_d = ST_MEMWAIT;
        end else begin
          state_d   = ST_RUN;
          pipe_hold = 1'b0;
          if (hazard) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = branch_taken_i;
          end
        end
      end
      default: begin
        if (start_i) state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && (pipe_hold || id_ex_bubble) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_write_o     = pc_write;
  assign IF_ID_write_o  = if_id_write;
  assign IF_ID_flush_o  = if_id_flush;
  assign ID_EX_bubble_o = id_ex_bubble;
  assign pipe_hold_o    = pipe_hold;
  assign state_o        = state_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule
